// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite definitions for the memory slave.
//   - HTRANS / HSIZE / HRESP codes
//   - responder FSM state type
//   - byte_lanes(): byte-lane enables for a transfer from (size, low address bits)
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

    // Little-endian byte-lane enables for a bus of (1 << max_size) bytes.
    // An oversize request is clamped to a full-word access and address bits
    // below the access size are ignored, so the lane group is always aligned.
    function automatic logic [7:0] byte_lanes(input logic [2:0] size,
                                              input logic [2:0] addr_lo,
                                              input logic [2:0] max_size);
        logic [2:0] sz;
        logic [3:0] nbytes;
        logic [2:0] word_mask;
        logic [2:0] off;
        logic [7:0] m;
        sz        = (size > max_size) ? max_size : size;
        nbytes    = 4'd1 << sz;
        word_mask = ~(3'b111 << max_size);
        off       = addr_lo & word_mask & ~(nbytes[2:0] - 3'd1);
        m         = 8'hFF >> (4'd8 - nbytes);
        return m << off;
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// ahb_slave_ram: MEM_DEPTH x DATA_WIDTH single-port storage.
//   clk    in   clock
//   we     in   write enable (commits on the rising edge)
//   be     in   byte-lane enables, bit i covers wdata[8*i+7:8*i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  asynchronous read of the word at addr
// Contents are not reset.
module ahb_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite responder with a word-organised RAM and
// programmable wait states. Address phase of transfer N+1 overlaps the
// data phase of transfer N.
//
// Optional feature macro: AHB_SLAVE_ERR_EN
//   defined   - out-of-range, misaligned and oversize transfers get a
//               two-cycle ERROR response and never touch the RAM
//   undefined - HRESP is tied OKAY; addresses wrap, low bits below the size
//               are ignored, oversize accesses act as full-word accesses
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY   AHB-Lite inputs
//   HREADYOUT, HRESP, HRDATA                             slave response
//   dbg_state           current FSM state (ahb_state_e encoding)
//
// Handshake: a transfer is accepted at a rising edge where
// HSEL & HREADY & HTRANS[1]; its data phase then runs until a cycle in which
// this slave drives HREADYOUT=1, which is the cycle that completes it. While
// HREADYOUT=0 the master holds the next address phase and nothing is accepted.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic [2:0]            dbg_state
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int S     = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);
    localparam int LW    = IW + S;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ahb_state_e      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [LW-1:0]   addr_q;
    logic            wr_q;
    logic [2:0]      size_q;
    logic            accept;
    logic            take;
    logic            err_req;
    logic [7:0]      lanes;
    logic [BYTES-1:0] be;
    logic            we;
    logic [DATA_WIDTH-1:0] rdata;
    logic            unused_bits;

    assign accept = HSEL & HREADY & HTRANS[1];

`ifdef AHB_SLAVE_ERR_EN
    logic out_of_range, misaligned, oversize;
    assign out_of_range = |(HADDR >> LW);
    assign misaligned   = |(HADDR[6:0] & ((7'd1 << HSIZE) - 7'd1));
    assign oversize     = HSIZE > 3'(S);
    assign err_req      = out_of_range | misaligned | oversize;
    assign unused_bits  = HTRANS[0];
    assign HRESP        = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
    assign err_req      = 1'b0;
    assign unused_bits  = HTRANS[0] ^ (^HADDR[ADDR_WIDTH-1:LW]);
    assign HRESP        = HRESP_OKAY;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (take) begin
                addr_q <= HADDR[LW-1:0];
                wr_q   <= HWRITE;
                size_q <= HSIZE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        take      = 1'b0;
        HREADYOUT = 1'b1;
        case (state_q)
            // IDLE, DATA and ERR2 all end with HREADYOUT=1, so each may
            // accept the next address phase in the same way.
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    take = 1'b1;
                    if (err_req) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The write lands at the DATA edge, before any back-to-back read's data
    // phase, so read-after-write sees the new word without forwarding.
    assign lanes = byte_lanes(size_q, 3'(addr_q[S-1:0]), 3'(S));
    assign be    = lanes[BYTES-1:0];
    assign we    = (state_q == ST_DATA) && wr_q;

    logic unused_lanes;
    assign unused_lanes = ^lanes ^ unused_bits;

    ahb_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (HCLK),
        .we    (we),
        .be    (be),
        .addr  (addr_q[LW-1:S]),
        .wdata (HWDATA),
        .rdata (rdata)
    );

    assign HRDATA    = ((state_q == ST_DATA) && !wr_q) ? rdata : '0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: directed bench for ahb_mem_slave. Two instances share the
// bus signals: u_dut0 has no wait states, u_dut2 has two. Each has its own
// HSEL and its HREADY fed back from its own HREADYOUT.
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    logic        clk;
    logic        hreset;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        ro0, rs0, ro2, rs2;
    logic [31:0] rd0, rd2;
    logic [2:0]  dbg0, dbg2;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
        .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0), .dbg_state(dbg0)
    );

    ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESET(hreset), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro2),
        .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2), .dbg_state(dbg2)
    );

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input bit on2, input logic [1:0] tr, input bit wr,
                              input logic [31:0] a, input logic [2:0] sz);
        hsel0  = !on2;
        hsel2  = on2;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    // Leaves the caller at the negedge of the completing data-phase cycle.
    task automatic wait_ready(input bit on2, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(on2 ? ro2 : ro0) && n < 32) begin
            cycle();
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(on2 ? ro2 : ro0), 32'd1);
    endtask

    task automatic do_write(input bit on2, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d, input string tag);
        addr_phase(on2, HTRANS_NONSEQ, 1'b1, a, sz);
        cycle();
        bus_idle();
        hwdata = d;
        wait_ready(on2, tag);
        cycle();
    endtask

    task automatic do_read(input bit on2, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] exp, input string tag);
        addr_phase(on2, HTRANS_NONSEQ, 1'b0, a, sz);
        cycle();
        bus_idle();
        wait_ready(on2, tag);
        check({tag, "_rdata"}, on2 ? rd2 : rd0, exp);
        check({tag, "_resp"}, 32'(on2 ? rs2 : rs0), 32'd0);
        cycle();
    endtask

    // Erroneous write on u_dut0: ERR1 (0/1) then ERR2 (1/1) then OKAY idle.
    task automatic err_write(input logic [31:0] a, input logic [2:0] sz,
                             input logic [31:0] d, input string tag);
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, a, sz);
        cycle();
        bus_idle();
        hwdata = d;
        @(negedge clk);
        check({tag, "_e1_ready"}, 32'(ro0), 32'd0);
        check({tag, "_e1_resp"},  32'(rs0), 32'd1);
        cycle();
        @(negedge clk);
        check({tag, "_e2_ready"}, 32'(ro0), 32'd1);
        check({tag, "_e2_resp"},  32'(rs0), 32'd1);
        cycle();
        @(negedge clk);
        check({tag, "_after_resp"}, 32'(rs0), 32'd0);
        cycle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        hreset = 1'b1;
        haddr  = 32'h0;
        hsize  = HSIZE_WORD;
        hwdata = 32'h0;
        bus_idle();
        repeat (3) cycle();
        @(negedge clk);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0",  32'(rs0), 32'd0);
        check("rst_rdata0", rd0, 32'd0);
        check("rst_ready2", 32'(ro2), 32'd1);
        check("rst_state2", 32'(dbg2), 32'(ST_IDLE));
        hreset = 1'b0;
        cycle();

        // 1: zero-wait write then back-to-back read of the same word
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD);
        cycle();
        hwdata = 32'hDEADBEEF;
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD);
        @(negedge clk);
        check("t1_wr_ready", 32'(ro0), 32'd1);
        check("t1_wr_rdata", rd0, 32'd0);
        cycle();
        bus_idle();
        @(negedge clk);
        check("t1_rd_ready", 32'(ro0), 32'd1);
        check("t1_rd_rdata", rd0, 32'hDEADBEEF);
        check("t1_rd_resp",  32'(rs0), 32'd0);
        cycle();
        @(negedge clk);
        check("t1_idle_rdata", rd0, 32'd0);

        // 2: two wait states on a read
        do_write(1'b1, 32'h40, HSIZE_WORD, 32'h0BADF00D, "t2_pre");
        addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD);
        cycle();
        bus_idle();
        @(negedge clk);
        check("t2_c1_ready", 32'(ro2), 32'd0);
        check("t2_c1_rdata", rd2, 32'd0);
        check("t2_c1_resp",  32'(rs2), 32'd0);
        cycle();
        @(negedge clk);
        check("t2_c2_ready", 32'(ro2), 32'd0);
        check("t2_c2_rdata", rd2, 32'd0);
        check("t2_c2_resp",  32'(rs2), 32'd0);
        cycle();
        @(negedge clk);
        check("t2_c3_ready", 32'(ro2), 32'd1);
        check("t2_c3_rdata", rd2, 32'h0BADF00D);
        check("t2_c3_resp",  32'(rs2), 32'd0);
        cycle();

        // 3: byte writes over a word; other lanes carry junk that must not land
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD);
        cycle();
        hwdata = 32'hAABBCCDD;
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h21, HSIZE_BYTE);
        cycle();
        hwdata = 32'hEEEE11EE;
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h23, HSIZE_BYTE);
        cycle();
        hwdata = 32'h22FFFFFF;
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD);
        cycle();
        bus_idle();
        @(negedge clk);
        check("t3_bytes", rd0, 32'h22BB11DD);
        cycle();
        do_write(1'b0, 32'h30, HSIZE_WORD, 32'h00000000, "t3_hpre");
        do_write(1'b0, 32'h32, HSIZE_HALF, 32'h1234ABCD, "t3_half");
        do_read(1'b0, 32'h30, HSIZE_WORD, 32'h12340000, "t3_hread");

        // 4: IDLE/BUSY with HSEL=1 and NONSEQ with HSEL=0 transfer nothing
        do_write(1'b0, 32'h50, HSIZE_WORD, 32'h01234567, "t4_pre");
        addr_phase(1'b0, HTRANS_IDLE, 1'b1, 32'h50, HSIZE_WORD);
        cycle();
        hwdata = 32'hFFFFFFFF;
        addr_phase(1'b0, HTRANS_BUSY, 1'b1, 32'h50, HSIZE_WORD);
        @(negedge clk);
        check("t4_idle_ready", 32'(ro0), 32'd1);
        check("t4_idle_resp",  32'(rs0), 32'd0);
        check("t4_idle_state", 32'(dbg0), 32'(ST_IDLE));
        cycle();
        addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h50, HSIZE_WORD);
        hsel0 = 1'b0;
        @(negedge clk);
        check("t4_busy_ready", 32'(ro0), 32'd1);
        check("t4_busy_resp",  32'(rs0), 32'd0);
        cycle();
        bus_idle();
        @(negedge clk);
        check("t4_nosel_ready", 32'(ro0), 32'd1);
        check("t4_nosel_state", 32'(dbg0), 32'(ST_IDLE));
        cycle();
        do_read(1'b0, 32'h50, HSIZE_WORD, 32'h01234567, "t4_ram");

        // 5: out-of-range, misaligned and oversize accesses
        do_write(1'b0, 32'h00, HSIZE_WORD, 32'hCAFE0000, "t5_pre0");
        do_write(1'b0, 32'h60, HSIZE_WORD, 32'hFFFFFFFF, "t5_pre60");
        do_write(1'b0, 32'h70, HSIZE_WORD, 32'h00000000, "t5_pre70");
`ifdef AHB_SLAVE_ERR_EN
        err_write(32'h400, HSIZE_WORD, 32'h12345678, "t5_oor");
        do_read(1'b0, 32'h00, HSIZE_WORD, 32'hCAFE0000, "t5_oor_ram");
        err_write(32'h61, HSIZE_HALF, 32'h0000AAAA, "t5_mis");
        do_read(1'b0, 32'h60, HSIZE_WORD, 32'hFFFFFFFF, "t5_mis_ram");
        err_write(32'h70, HSIZE_DWORD, 32'h76543210, "t5_big");
        do_read(1'b0, 32'h70, HSIZE_WORD, 32'h00000000, "t5_big_ram");
`else
        do_write(1'b0, 32'h400, HSIZE_WORD, 32'h12345678, "t5_oor");
        do_read(1'b0, 32'h00, HSIZE_WORD, 32'h12345678, "t5_oor_ram");
        do_write(1'b0, 32'h61, HSIZE_HALF, 32'h0000AAAA, "t5_mis");
        do_read(1'b0, 32'h60, HSIZE_WORD, 32'hFFFFAAAA, "t5_mis_ram");
        do_write(1'b0, 32'h70, HSIZE_DWORD, 32'h76543210, "t5_big");
        do_read(1'b0, 32'h70, HSIZE_WORD, 32'h76543210, "t5_big_ram");
`endif

        // 6: reset during a wait state abandons the write
        do_write(1'b1, 32'h80, HSIZE_WORD, 32'h5A5A5A5A, "t6_pre");
        addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 32'h80, HSIZE_WORD);
        cycle();
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        hreset = 1'b1;
        @(negedge clk);
        check("t6_wait_ready", 32'(ro2), 32'd0);
        check("t6_wait_state", 32'(dbg2), 32'(ST_WAIT));
        cycle();
        hreset = 1'b0;
        @(negedge clk);
        check("t6_rst_ready", 32'(ro2), 32'd1);
        check("t6_rst_resp",  32'(rs2), 32'd0);
        check("t6_rst_rdata", rd2, 32'd0);
        check("t6_rst_state", 32'(dbg2), 32'(ST_IDLE));
        cycle();
        repeat (3) cycle();
        do_read(1'b1, 32'h80, HSIZE_WORD, 32'h5A5A5A5A, "t6_ram");

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
